// File: rtl/ecc_secded_decoder.sv
// Streaming SECDED (extended Hamming) decoder, 2-stage pipeline.
// Stage 1 computes syndrome/parity; stage 2 corrects and classifies.
package ecc_pkg;

  function automatic int get_parity_width(input int k);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << r) < k + r + 1) r = i + 1;
    end
    return r;
  endfunction

  function automatic int get_cw_width(input int k);
    return k + get_parity_width(k);
  endfunction

endpackage

module ecc_secded_decoder
  import ecc_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int CntWidth  = 16,
  localparam int ParWidth = get_parity_width(DataWidth),
  localparam int CwWidth  = DataWidth + ParWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [CwWidth:0]     cw_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 single_err_o,
  output logic                 double_err_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  input  logic                 clr_i,
  output logic [CntWidth-1:0]  corr_cnt_o,
  output logic [CntWidth-1:0]  uncorr_cnt_o
);

  // Codeword index of data bit k: k-th non-power-of-two position.
  function automatic int data_pos(input int k);
    int j;
    int res;
    j   = 0;
    res = 0;
    for (int i = 1; i <= CwWidth; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (j == k) res = i - 1;
        j++;
      end
    end
    return res;
  endfunction

  logic                 s1_valid_q;
  logic [CwWidth-1:0]   s1_cw_q;
  logic [ParWidth-1:0]  s1_syn_q;
  logic                 s1_par_q;

  logic                 valid_q;
  logic [DataWidth-1:0] data_q;
  logic                 single_q;
  logic                 double_q;

  logic [CntWidth-1:0]  corr_q;
  logic [CntWidth-1:0]  corr_d;
  logic [CntWidth-1:0]  uncorr_q;
  logic [CntWidth-1:0]  uncorr_d;

  logic [ParWidth-1:0]  syn_d;
  logic                 par_d;
  logic [CwWidth-1:0]   fix;
  logic [DataWidth-1:0] data_d;
  logic                 single_d;
  logic                 double_d;
  logic                 syn_zero;
  logic                 syn_ok;

  logic s2_adv;
  logic in_fire;
  logic out_fire;

  assign out_fire = valid_q & ready_i;
  assign s2_adv   = ~valid_q | ready_i;
  assign ready_o  = ~s1_valid_q | s2_adv;
  assign in_fire  = valid_i & ready_o;

  always_comb begin
    syn_d = '0;
    for (int i = 0; i < CwWidth; i++) begin
      if (cw_i[i]) syn_d = syn_d ^ ParWidth'(i + 1);
    end
    par_d = ^cw_i;
  end

  assign syn_zero = (s1_syn_q == '0);
  assign syn_ok   = !syn_zero && (int'(s1_syn_q) <= CwWidth);

  always_comb begin
    fix      = s1_cw_q;
    single_d = 1'b0;
    double_d = 1'b0;
    if (s1_par_q) begin
      for (int i = 0; i < CwWidth; i++) begin
        if (s1_syn_q == ParWidth'(i + 1)) fix[i] = ~fix[i];
      end
    end
    unique case (1'b1)
      syn_zero && !s1_par_q:         ;
      s1_par_q && (syn_zero || syn_ok): single_d = 1'b1;
      default:                       double_d = 1'b1;
    endcase
  end

  for (genvar k = 0; k < DataWidth; k++) begin : g_ext
    localparam int DPos = data_pos(k);
    assign data_d[k] = fix[DPos];
  end

  // Clear dominates any increment on the same edge.
  always_comb begin
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    if (clr_i) begin
      corr_d   = '0;
      uncorr_d = '0;
    end else if (out_fire) begin
      if (single_q && corr_q != '1)   corr_d   = corr_q + 1'b1;
      if (double_q && uncorr_q != '1) uncorr_d = uncorr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_cw_q    <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      single_q   <= 1'b0;
      double_q   <= 1'b0;
      corr_q     <= '0;
      uncorr_q   <= '0;
    end else begin
      if (ready_o) s1_valid_q <= valid_i;
      if (in_fire) begin
        s1_cw_q  <= cw_i[CwWidth-1:0];
        s1_syn_q <= syn_d;
        s1_par_q <= par_d;
      end
      if (s2_adv) valid_q <= s1_valid_q;
      if (s2_adv && s1_valid_q) begin
        data_q   <= data_d;
        single_q <= single_d;
        double_q <= double_d;
      end
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign single_err_o = single_q;
  assign double_err_o = double_q;
  assign corr_cnt_o   = corr_q;
  assign uncorr_cnt_o = uncorr_q;

endmodule

// File: tb/tb_ecc_secded_decoder.sv
// Bench for ecc_secded_decoder: directed cases plus random words
// checked against an error-injection reference model.
module tb_ecc_secded_decoder;

  localparam int CNTW = 2;
  localparam int CMAX = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [38:0] cw_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] data_o;
  logic        single_err_o;
  logic        double_err_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        clr_i = 1'b0;
  logic [CNTW-1:0] corr_cnt_o;
  logic [CNTW-1:0] uncorr_cnt_o;

  ecc_secded_decoder #(.DataWidth(32), .CntWidth(CNTW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cw_i(cw_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .single_err_o(single_err_o),
    .double_err_o(double_err_o), .valid_o(valid_o), .ready_i(ready_i),
    .clr_i(clr_i), .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] d;
    logic        se;
    logic        de;
  } exp_t;

  exp_t q[$];
  int   ncmp = 0;
  int   nerr = 0;
  int   dpos[32];
  bit   mon_en = 0;
  bit   rnd_rdy = 0;
  int   exp_corr = 0;
  int   exp_unc = 0;
  bit   hold = 0;
  logic [33:0] held;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Parity bits chosen so the XOR of set-bit positions becomes zero.
  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [38:0] c;
    int s;
    c = '0;
    s = 0;
    for (int k = 0; k < 32; k++) begin
      if (d[k]) begin
        c[dpos[k]-1] = 1'b1;
        s = s ^ dpos[k];
      end
    end
    for (int b = 0; b < 6; b++) c[(1 << b) - 1] = s[b];
    c[38] = ^c[37:0];
    return c;
  endfunction

  function automatic logic [31:0] extract(input logic [38:0] c);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[k] = c[dpos[k]-1];
    return r;
  endfunction

  always @(posedge clk_i) begin
    if (rnd_rdy) begin
      #1;
      ready_i = ($urandom_range(3) != 0);
    end
  end

  always @(negedge clk_i) begin
    if (mon_en) begin
      exp_t e;
      int nc;
      int nu;
      chk("corr_cnt", corr_cnt_o, exp_corr);
      chk("uncorr_cnt", uncorr_cnt_o, exp_unc);
      if (hold) chk("stable", {data_o, single_err_o, double_err_o}, held);
      hold = 0;
      nc = exp_corr;
      nu = exp_unc;
      if (!rst_ni) begin
        q.delete();
        nc = 0;
        nu = 0;
      end else begin
        if (valid_o && ready_i) begin
          if (q.size() == 0) begin
            ncmp++;
            nerr++;
            $error("FAIL unexpected_out observed=%0h expected=none", data_o);
          end else begin
            e = q.pop_front();
            chk("data", data_o, e.d);
            chk("single", single_err_o, e.se);
            chk("double", double_err_o, e.de);
            if (e.se && nc < CMAX) nc++;
            if (e.de && nu < CMAX) nu++;
          end
        end else if (valid_o) begin
          hold = 1;
          held = {data_o, single_err_o, double_err_o};
        end
        if (clr_i) begin
          nc = 0;
          nu = 0;
        end
      end
      exp_corr = nc;
      exp_unc  = nu;
    end
  end

  task automatic send(input logic [38:0] cw, input logic [31:0] d,
                      input logic se, input logic de);
    int n;
    exp_t e;
    n = 0;
    cw_i = cw;
    valid_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (ready_o) break;
      n++;
      if (n > 200) break;
    end
    if (!ready_o) begin
      ncmp++;
      nerr++;
      $error("FAIL send_timeout observed=%0d expected=<200", n);
    end else begin
      e.d = d;
      e.se = se;
      e.de = de;
      q.push_back(e);
    end
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk_i);
      n++;
    end
    chk("drain", q.size(), 0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_rand();
    logic [31:0] d;
    logic [38:0] c;
    int nf;
    int p1;
    int p2;
    d  = $urandom;
    c  = enc(d);
    nf = $urandom_range(2);
    p1 = $urandom_range(38);
    p2 = $urandom_range(38);
    while (p2 == p1) p2 = $urandom_range(38);
    if (nf == 0) send(c, d, 1'b0, 1'b0);
    else if (nf == 1) begin
      c[p1] = ~c[p1];
      send(c, d, 1'b1, 1'b0);
    end else begin
      c[p1] = ~c[p1];
      c[p2] = ~c[p2];
      send(c, extract(c), 1'b0, 1'b1);
    end
  endtask

  initial begin
    logic [38:0] c;
    logic [31:0] d;
    int j;
    int n;
    j = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        dpos[j] = p;
        j++;
      end
    end

    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    mon_en = 1;
    @(negedge clk_i);
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_data", data_o, 0);
    chk("rst_flags", {single_err_o, double_err_o}, 0);
    @(posedge clk_i);
    #1;

    send('0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("lat_cyc1", valid_o, 0);
    @(negedge clk_i);
    chk("lat_cyc2", valid_o, 1);
    @(posedge clk_i);
    #1;
    repeat (3) send('0, '0, 1'b0, 1'b0);
    drain();

    c = '0;
    c[5] = 1'b1;
    send(c, '0, 1'b1, 1'b0);
    drain();
    chk("corr_after_pos6", corr_cnt_o, 1);

    c = '0;
    c[38] = 1'b1;
    send(c, '0, 1'b1, 1'b0);

    c = '0;
    c[0] = 1'b1;
    c[1] = 1'b1;
    send(c, '0, 1'b0, 1'b1);
    drain();
    chk("uncorr_after_s3", uncorr_cnt_o, 1);

    d = $urandom;
    c = enc(d);
    c[31] = ~c[31];
    c[6]  = ~c[6];
    c[38] = ~c[38];
    send(c, extract(c), 1'b0, 1'b1);
    drain();

    ready_i = 1'b0;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          d = $urandom;
          send(enc(d), d, 1'b0, 1'b0);
        end
      end
      begin
        repeat (4) @(negedge clk_i);
        chk("bp_ready", ready_o, 0);
        chk("bp_valid", valid_o, 1);
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
      end
    join
    drain();

    for (int k = 0; k < 5; k++) begin
      d = $urandom;
      c = enc(d);
      c[k + 10] = ~c[k + 10];
      send(c, d, 1'b1, 1'b0);
    end
    drain();
    chk("corr_sat", corr_cnt_o, 3);

    d = $urandom;
    c = enc(d);
    c[2] = ~c[2];
    send(c, d, 1'b1, 1'b0);
    n = 0;
    while (!(valid_o && ready_i) && n < 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    clr_i = 1'b0;
    @(negedge clk_i);
    chk("clr_corr", corr_cnt_o, 0);
    chk("clr_uncorr", uncorr_cnt_o, 0);
    @(posedge clk_i);
    #1;

    rnd_rdy = 1;
    for (int k = 0; k < 80; k++) send_rand();
    rnd_rdy = 0;
    @(posedge clk_i);
    #2;
    ready_i = 1'b1;
    drain();

    send_rand();
    send_rand();
    send_rand();
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_corr", corr_cnt_o, 0);
    chk("mid_rst_uncorr", uncorr_cnt_o, 0);
    chk("mid_rst_ready", ready_o, 1);
    @(posedge clk_i);
    #1;

    for (int k = 0; k < 4; k++) send_rand();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
